// File: rtl/regfile_sb.sv
//------------------------------------------------------------------------------
// Module   : regfile_sb
// Purpose  : Two-read / one-write register file with a per-register
//            scoreboard of pending writes (issue increments, writeback
//            retires) and a registered WWD output port.
// Ports    : clk, reset_n        - clock, asynchronous active-low reset
//            rd_addr1/2, rd_data1/2 - combinational read ports
//            wr_en, wr_addr, wr_data, wwd - writeback (wwd routes to output_port)
//            output_port        - registered WWD result
//            iss_en, iss_addr   - destination-register issue
//            flush              - drop all pending writes
//            hazard1/2          - pending write on rd_addr1/2
//            sb_full            - counter of iss_addr saturated
//            err_underflow      - sticky retire-without-pending flag
// Config   : REGFILE_SB_BYPASS_EN - write-through read data and hazard
//            release when a retire hits the read address in the same cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_sb #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REGS  = 4,
  parameter int ADDR_W    = 2,
  parameter int CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    rd_addr1,
  input  logic [ADDR_W-1:0]    rd_addr2,
  output logic [WORD_SIZE-1:0] rd_data1,
  output logic [WORD_SIZE-1:0] rd_data2,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 wwd,
  output logic [WORD_SIZE-1:0] output_port,
  input  logic                 iss_en,
  input  logic [ADDR_W-1:0]    iss_addr,
  input  logic                 flush,
  output logic                 hazard1,
  output logic                 hazard2,
  output logic                 sb_full,
  output logic                 err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WORD_SIZE-1:0] mem_q [NUM_REGS];
  logic [CNT_W-1:0]     cnt_q [NUM_REGS];
  logic [CNT_W-1:0]     cnt_d [NUM_REGS];
  logic [WORD_SIZE-1:0] out_q;
  logic                 err_q;
  logic                 err_d;

  logic retire;
  logic retire_at_iss;
  logic issue;
  logic underflow;

  assign retire        = wr_en & ~wwd;
  assign retire_at_iss = retire && (wr_addr == iss_addr);
  // A same-cycle retire to the saturated register frees a slot.
  assign sb_full       = (cnt_q[iss_addr] == CNT_MAX) && !retire_at_iss;
  assign issue         = iss_en && !sb_full;
  assign underflow     = retire && (cnt_q[wr_addr] == '0);
  assign err_d         = err_q | underflow;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      logic inc;
      logic dec;

      assign inc = issue  && (iss_addr == ADDR_W'(i));
      assign dec = retire && (wr_addr  == ADDR_W'(i));

      // Issue and retire to the same register cancel out.
      always_comb begin
        cnt_d[i] = cnt_q[i];
        if (flush) begin
          cnt_d[i] = '0;
        end else if (inc && !dec) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end else if (dec && !inc && (cnt_q[i] != '0)) begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          mem_q[i] <= '0;
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_d[i];
          // Array write happens even under flush or underflow.
          if (dec) begin
            mem_q[i] <= wr_data;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (wr_en && wwd) begin
        out_q <= wr_data;
      end
    end
  end

  assign output_port   = out_q;
  assign err_underflow = err_q;

`ifdef REGFILE_SB_BYPASS_EN
  logic hit1;
  logic hit2;

  assign hit1     = retire && (wr_addr == rd_addr1);
  assign hit2     = retire && (wr_addr == rd_addr2);
  assign rd_data1 = hit1 ? wr_data : mem_q[rd_addr1];
  assign rd_data2 = hit2 ? wr_data : mem_q[rd_addr2];
  // The last pending write retiring now no longer blocks the reader.
  assign hazard1  = (cnt_q[rd_addr1] != '0) && !(hit1 && (cnt_q[rd_addr1] == CNT_ONE));
  assign hazard2  = (cnt_q[rd_addr2] != '0) && !(hit2 && (cnt_q[rd_addr2] == CNT_ONE));
`else
  assign rd_data1 = mem_q[rd_addr1];
  assign rd_data2 = mem_q[rd_addr2];
  assign hazard1  = (cnt_q[rd_addr1] != '0);
  assign hazard2  = (cnt_q[rd_addr2] != '0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
//------------------------------------------------------------------------------
// Module   : tb_regfile_sb
// Purpose  : Directed-vector scoreboard bench for regfile_sb. Stimulus pushes
//            expected observations into a queue; a monitor pops and compares
//            them on the falling clock edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_sb;

  localparam int W = 16;
  localparam int A = 2;

  localparam int K_RD1 = 0;
  localparam int K_RD2 = 1;
  localparam int K_HZ1 = 2;
  localparam int K_HZ2 = 3;
  localparam int K_FUL = 4;
  localparam int K_OUT = 5;
  localparam int K_ERR = 6;

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [A-1:0] rd_addr1, rd_addr2, wr_addr, iss_addr;
  logic [W-1:0] rd_data1, rd_data2, wr_data, output_port;
  logic         wr_en, wwd, iss_en, flush;
  logic         hazard1, hazard2, sb_full, err_underflow;

  regfile_sb #(.WORD_SIZE(16), .NUM_REGS(4), .ADDR_W(2), .CNT_W(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rd_addr1      (rd_addr1),
    .rd_addr2      (rd_addr2),
    .rd_data1      (rd_data1),
    .rd_data2      (rd_data2),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wwd           (wwd),
    .output_port   (output_port),
    .iss_en        (iss_en),
    .iss_addr      (iss_addr),
    .flush         (flush),
    .hazard1       (hazard1),
    .hazard2       (hazard2),
    .sb_full       (sb_full),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           kind;
    logic [W-1:0] val;
    string        name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [W-1:0] actual(input int kind);
    case (kind)
      K_RD1:   return rd_data1;
      K_RD2:   return rd_data2;
      K_HZ1:   return W'(hazard1);
      K_HZ2:   return W'(hazard2);
      K_FUL:   return W'(sb_full);
      K_OUT:   return output_port;
      default: return W'(err_underflow);
    endcase
  endfunction

  // Monitor: every falling edge, compare all observations queued for it.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [W-1:0] a;
      e = q.pop_front();
      a = actual(e.kind);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, a, e.val, $time);
      end
    end
  end

  task automatic exp(input int kind, input logic [W-1:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    wwd    = 1'b0;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic issue(input logic [A-1:0] a);
    idle();
    iss_en   = 1'b1;
    iss_addr = a;
  endtask

  task automatic retire(input logic [A-1:0] a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wwd     = 1'b0;
    wr_addr = a;
    wr_data = d;
  endtask

  initial begin
    reset_n  = 1'b0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    wr_addr  = '0;
    iss_addr = '0;
    wr_data  = '0;
    idle();

    // Reset state
    exp(K_RD1, 16'h0, "rst_rd1");
    exp(K_RD2, 16'h0, "rst_rd2");
    exp(K_HZ1, 16'h0, "rst_hz1");
    exp(K_FUL, 16'h0, "rst_full");
    exp(K_OUT, 16'h0, "rst_out");
    exp(K_ERR, 16'h0, "rst_err");
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Issue r2, then retire r2=0x1234 while reading it
    issue(2'd2);
    rd_addr1 = 2'd2;
    exp(K_FUL, 16'h0, "iss_r2_full");
    tick();
    idle();
    exp(K_HZ1, 16'h1, "r2_pending");
    tick();
    retire(2'd2, 16'h1234);
    exp(K_RD1, BYP ? 16'h1234 : 16'h0000, "r2_same_cycle_rd");
    exp(K_HZ1, BYP ? 16'h0 : 16'h1, "r2_same_cycle_hz");
    tick();
    idle();
    exp(K_RD1, 16'h1234, "r2_read");
    exp(K_HZ1, 16'h0, "r2_hz_clear");
    exp(K_ERR, 16'h0, "r2_no_uflow");
    tick();

    // WWD: routes to output_port, r1 and cnt[1] untouched
    wr_en    = 1'b1;
    wwd      = 1'b1;
    wr_addr  = 2'd1;
    wr_data  = 16'hBEEF;
    rd_addr2 = 2'd1;
    exp(K_RD2, 16'h0, "wwd_no_bypass");
    exp(K_OUT, 16'h0, "wwd_out_before");
    tick();
    idle();
    exp(K_OUT, 16'hBEEF, "wwd_out");
    exp(K_RD2, 16'h0, "wwd_r1_unchanged");
    exp(K_HZ2, 16'h0, "wwd_cnt1_unchanged");
    exp(K_ERR, 16'h0, "wwd_no_uflow");
    tick();

    // Saturate r3
    rd_addr2 = 2'd3;
    for (int i = 0; i < 3; i++) begin
      issue(2'd3);
      exp(K_FUL, 16'h0, $sformatf("r3_iss%0d_full", i));
      tick();
    end
    issue(2'd3);
    exp(K_FUL, 16'h1, "r3_saturated");
    exp(K_HZ2, 16'h1, "r3_hz");
    tick();
    // Retire + issue same cycle: slot freed, count stays at 3
    issue(2'd3);
    retire(2'd3, 16'h0033);
    exp(K_FUL, 16'h0, "r3_retire_frees");
    exp(K_HZ2, 16'h1, "r3_hz_cnt3");
    tick();
    issue(2'd3);
    exp(K_FUL, 16'h1, "r3_still_full");
    exp(K_RD2, 16'h0033, "r3_data");
    tick();

    // Issue r1, then same-cycle retire r1=0x00AA
    issue(2'd1);
    rd_addr1 = 2'd1;
    tick();
    idle();
    retire(2'd1, 16'h00AA);
    exp(K_RD1, BYP ? 16'h00AA : 16'h0000, "r1_bypass_rd");
    exp(K_HZ1, BYP ? 16'h0 : 16'h1, "r1_bypass_hz");
    tick();
    idle();
    exp(K_RD1, 16'h00AA, "r1_read");
    exp(K_HZ1, 16'h0, "r1_hz_clear");
    tick();

    // Issue r0 and r2, flush with a same-cycle retire to r0
    issue(2'd0);
    tick();
    issue(2'd2);
    tick();
    idle();
    rd_addr1 = 2'd0;
    rd_addr2 = 2'd2;
    flush    = 1'b1;
    retire(2'd0, 16'h0F0F);
    exp(K_HZ2, 16'h1, "pre_flush_hz2");
    exp(K_HZ1, BYP ? 16'h0 : 16'h1, "pre_flush_hz1");
    tick();
    idle();
    exp(K_HZ1, 16'h0, "flush_hz1");
    exp(K_HZ2, 16'h0, "flush_hz2");
    exp(K_RD1, 16'h0F0F, "flush_keeps_write");
    exp(K_ERR, 16'h0, "flush_no_uflow");
    tick();
    // Retire r2 with nothing pending: underflow
    retire(2'd2, 16'h5555);
    exp(K_ERR, 16'h0, "uflow_not_yet");
    tick();
    idle();
    exp(K_ERR, 16'h1, "uflow_set");
    exp(K_RD2, 16'h5555, "uflow_still_writes");
    exp(K_HZ2, 16'h0, "uflow_cnt_zero");
    tick();
    exp(K_ERR, 16'h1, "uflow_sticky");
    tick();

    // Mid-operation reset: immediate clear
    issue(2'd2);
    tick();
    idle();
    rd_addr1 = 2'd2;
    rd_addr2 = 2'd0;
    exp(K_HZ1, 16'h1, "pre_rst_hz1");
    tick();
    reset_n = 1'b0;
    #1;
    if (rd_data1 !== 16'h0 || hazard1 !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: rd1=0x%0h hz1=%0b expected 0 and 0", rd_data1, hazard1);
    end
    checks++;
    exp(K_RD1, 16'h0, "mid_rst_rd1");
    exp(K_RD2, 16'h0, "mid_rst_rd2");
    exp(K_HZ1, 16'h0, "mid_rst_hz1");
    exp(K_HZ2, 16'h0, "mid_rst_hz2");
    exp(K_OUT, 16'h0, "mid_rst_out");
    exp(K_ERR, 16'h0, "mid_rst_err");
    tick();
    reset_n = 1'b1;
    tick();
    iss_addr = 2'd3;
    exp(K_FUL, 16'h0, "post_rst_full");
    exp(K_HZ1, 16'h0, "post_rst_hz1");
    tick();

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
